// File: rtl/multiword_add_seq.sv
// Multi-cycle adder: OPW-bit add processed one CHUNK_WIDTH chunk per clock through a shared adder.
// Optional subtract command enabled by defining MULTIWORD_ADD_SEQ_SUB_EN.
`timescale 1ns/1ps

module multiword_add_seq_adder #(
   parameter int WIDTH     = 4,
   parameter int ALGORITHM = 0   // 0 ripple-carry, 1 carry-look-ahead (WIDTH multiple of 4)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   generate
      if (ALGORITHM == 1) begin : g_cla
         logic       c;
         logic [3:0] g;
         logic [3:0] p;
         logic [3:0] cv;

         // Carries inside each 4-bit group come from lookahead terms; groups chain their carry.
         always_comb begin
            c  = ci;
            s  = '0;
            g  = '0;
            p  = '0;
            cv = '0;
            for (int grp = 0; grp < WIDTH / 4; grp++) begin
               g     = a[grp*4 +: 4] & b[grp*4 +: 4];
               p     = a[grp*4 +: 4] ^ b[grp*4 +: 4];
               cv[0] = c;
               cv[1] = g[0] | (p[0] & c);
               cv[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
               cv[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
               c     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                     | (p[3] & p[2] & p[1] & p[0] & c);
               s[grp*4 +: 4] = p ^ cv;
            end
            co = c;
         end
      end else begin : g_ripple
         logic c;

         // NOTE: blocking assignments in always_comb let c carry the ripple from bit to bit;
         // every output is given a value before the loop so no latch is inferred.
         always_comb begin
            c = ci;
            s = '0;
            for (int i = 0; i < WIDTH; i++) begin
               s[i] = a[i] ^ b[i] ^ c;
               c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
            co = c;
         end
      end
   endgenerate

endmodule

module multiword_add_seq #(
   parameter int CHUNK_WIDTH = 4,
   parameter int NUM_CHUNKS  = 4,
   parameter int ALGORITHM   = 0,
   parameter int OPW         = CHUNK_WIDTH * NUM_CHUNKS
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [OPW-1:0] in0,
   input  logic [OPW-1:0] in1,
   input  logic           cin,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
   input  logic           sub,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [OPW-1:0] sum,
   output logic           cout,
   output logic           busy
);

   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                   state;
   logic [CNT_W-1:0]         cnt;
   logic                     carry;
   logic [OPW-1:0]           op_a;
   logic [OPW-1:0]           op_b;
   logic [CHUNK_WIDTH-1:0]   add_s;
   logic                     add_co;
   logic                     accept;
   logic [OPW-1:0]           b_load;
   logic                     cin_load;

   assign accept = in_valid & in_ready;

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
   // Subtraction is a + ~b + 1; cout = 1 then means no borrow.
   assign b_load   = sub ? ~in1 : in1;
   assign cin_load = sub | cin;
`else
   assign b_load   = in1;
   assign cin_load = cin;
`endif

   multiword_add_seq_adder #(
      .WIDTH     (CHUNK_WIDTH),
      .ALGORITHM (ALGORITHM)
   ) u_adder (
      .a  (op_a[cnt*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .b  (op_b[cnt*CHUNK_WIDTH +: CHUNK_WIDTH]),
      .ci (carry),
      .s  (add_s),
      .co (add_co)
   );

   // NOTE: operand registers carry no reset; they are only read after an accept reloads them.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_a <= in0;
         op_b <= b_load;
      end
   end

   // The carry register holds cin for chunk 0 and the previous chunk's carry-out after that.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         carry     <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  carry    <= cin_load;
                  cnt      <= '0;
                  state    <= RUN;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            RUN: begin
               sum[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] <= add_s;
               carry <= add_co;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  cnt       <= '0;
                  cout      <= add_co;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: vector table, corner sequences and random traffic
// against a plain-arithmetic reference model (ripple, look-ahead and single-chunk instances).
`timescale 1ns/1ps

module tb_multiword_add_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [15:0] in0;
   logic [15:0] in1;
   logic        cin;
   logic        sub;
   logic        out_ready;
   logic        rdy0, ov0, co0, busy0;
   logic        rdy1, ov1, co1, busy1;
   logic [15:0] sum0, sum1;
   logic        iv2, ordy2, rdy2, ov2, co2, busy2;
   logic [15:0] sum2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   multiword_add_seq #(.CHUNK_WIDTH(4), .NUM_CHUNKS(4), .ALGORITHM(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in0(in0), .in1(in1), .cin(cin),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      .sub(sub),
`endif
      .out_valid(ov0), .out_ready(out_ready), .sum(sum0), .cout(co0), .busy(busy0));

   multiword_add_seq #(.CHUNK_WIDTH(4), .NUM_CHUNKS(4), .ALGORITHM(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in0(in0), .in1(in1), .cin(cin),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      .sub(sub),
`endif
      .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .cout(co1), .busy(busy1));

   multiword_add_seq #(.CHUNK_WIDTH(16), .NUM_CHUNKS(1), .ALGORITHM(1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .in0(in0), .in1(in1), .cin(cin),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      .sub(sub),
`endif
      .out_valid(ov2), .out_ready(ordy2), .sum(sum2), .cout(co2), .busy(busy2));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      int          hold;
      logic [15:0] exp_sum;
      logic        exp_co;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: full-precision arithmetic; subtract gives a-b with cout = no borrow.
   function automatic logic [16:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                             input logic c, input logic s);
      if (s) return {(a >= b), 16'(a - b)};
      return 17'(a) + 17'(b) + 17'(c);
   endfunction

   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s, input int hold, input bit glitch,
                         input logic [15:0] es, input logic eco);
      int lat;
      @(negedge clk);
      check({name, " in_ready"}, 32'(rdy0), 32'd1);
      in0 = a; in1 = b; cin = c; sub = s; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in0 = 16'($urandom); in1 = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      if (glitch) begin
         in_valid = 1'b1;
         in0      = 16'hAAAA;
      end
      lat = 1;
      while (!ov0 && lat < 20) begin
         @(negedge clk);
         in_valid = 1'b0;
         lat++;
      end
      check({name, " latency"}, 32'(lat), 32'd5);
      check({name, " ov_cla"}, 32'(ov1), 32'd1);
      check({name, " sum"}, 32'(sum0), 32'(es));
      check({name, " cout"}, 32'(co0), 32'(eco));
      check({name, " sum_cla"}, 32'(sum1), 32'(es));
      check({name, " cout_cla"}, 32'(co1), 32'(eco));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({name, " hold sum"}, 32'(sum0), 32'(es));
         check({name, " hold cout"}, 32'(co0), 32'(eco));
         check({name, " hold ov"}, 32'(ov0), 32'd1);
         check({name, " hold in_ready"}, 32'(rdy0), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({name, " ov drop"}, 32'(ov0), 32'd0);
      check({name, " in_ready back"}, 32'(rdy0), 32'd1);
   endtask

   vec_t        vecs[6];
   logic [16:0] r;

   initial begin
      int   first_rise, second_rise, lat;
      logic prev_ov;

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1};
      vecs[1] = '{16'h1234, 16'h4321, 1'b1, 3, 16'h5556, 1'b0};
      vecs[2] = '{16'h0000, 16'h0000, 1'b0, 1, 16'h0000, 1'b0};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 2, 16'h0000, 1'b1};
      vecs[5] = '{16'h0F0F, 16'h00F1, 1'b1, 0, 16'h1001, 1'b0};

      rst = 1'b1; in_valid = 1'b0; in0 = '0; in1 = '0; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b0; iv2 = 1'b0; ordy2 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("reset in_ready", 32'(rdy0), 32'd1);
      check("reset out_valid", 32'(ov0), 32'd0);
      check("reset sum", 32'(sum0), 32'd0);
      check("reset cout", 32'(co0), 32'd0);
      check("reset busy", 32'(busy0), 32'd0);
      check("reset in_ready n1", 32'(rdy2), 32'd1);

      for (int i = 0; i < 6; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, 1'b0, vecs[i].hold, 1'b0,
                vecs[i].exp_sum, vecs[i].exp_co);

      // in_valid pulse with a different operand during RUN must not disturb the result
      run_op("ignore", 16'h1234, 16'h0001, 1'b0, 1'b0, 0, 1'b1, 16'h1235, 1'b0);
      @(negedge clk);
      check("ignore stays idle", 32'(busy0), 32'd0);

      // Abort in the second RUN cycle
      @(negedge clk);
      in0 = 16'h1111; in1 = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort out_valid", 32'(ov0), 32'd0);
      check("abort sum", 32'(sum0), 32'd0);
      check("abort cout", 32'(co0), 32'd0);
      check("abort in_ready", 32'(rdy0), 32'd1);
      check("abort in_ready cla", 32'(rdy1), 32'd1);
      repeat (6) @(negedge clk);
      check("abort not resumed", 32'(ov0), 32'd0);
      run_op("after abort", 16'h0002, 16'h0003, 1'b0, 1'b0, 0, 1'b0, 16'h0005, 1'b0);

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
      run_op("sub borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 16'hFFFE, 1'b0);
      run_op("sub noborrow", 16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0, 16'h0002, 1'b1);
`endif

      // Back-to-back with in_valid and out_ready held high: period must be NUM_CHUNKS+2
      @(negedge clk);
      in0 = 16'h0100; in1 = 16'h0200; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      first_rise = -1; second_rise = -1; prev_ov = 1'b0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(negedge clk);
         if (ov0 && !prev_ov) begin
            check("b2b sum", 32'(sum0), 32'h0300);
            if (first_rise < 0) first_rise = cyc;
            else if (second_rise < 0) second_rise = cyc;
         end
         prev_ov = ov0;
      end
      check("b2b period", 32'(second_rise - first_rise), 32'd6);
      in_valid = 1'b0;
      lat = 0;
      while (!(rdy0 && rdy1) && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      out_ready = 1'b0;
      check("b2b drained", 32'(rdy0 && rdy1), 32'd1);

      // Single-chunk instance: one RUN cycle, out_valid in the second cycle after accept
      @(negedge clk);
      check("n1 in_ready", 32'(rdy2), 32'd1);
      in0 = 16'hFFFF; in1 = 16'h0001; cin = 1'b1; sub = 1'b0; iv2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      iv2 = 1'b0;
      check("n1 run ov", 32'(ov2), 32'd0);
      check("n1 busy", 32'(busy2), 32'd1);
      @(negedge clk);
      check("n1 ov", 32'(ov2), 32'd1);
      check("n1 sum", 32'(sum2), 32'h0001);
      check("n1 cout", 32'(co2), 32'd1);
      ordy2 = 1'b1;
      @(negedge clk);
      ordy2 = 1'b0;
      check("n1 ov drop", 32'(ov2), 32'd0);
      check("n1 in_ready back", 32'(rdy2), 32'd1);

      // Random traffic against the reference model
      for (int n = 0; n < 1000; n++) begin
         logic [15:0] a, b;
         logic        c, s;
         a = 16'($urandom);
         b = 16'($urandom);
         c = 1'($urandom);
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         r = ref_model(a, b, c, s);
         run_op("rand", a, b, c, s, int'($urandom_range(0, 2)), 1'b0, r[15:0], r[16]);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
